// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - burst read controller for SRAM port B with credit-limited output FIFO
//
// Accepts {start address, length-1} requests and issues one SRAM read per cycle
// on port B. Read data (1-cycle latency) is captured into a small FIFO and
// presented as a valid/ready stream with a last-word tag. A read is only issued
// when the FIFO is guaranteed to have room for its data.
//
// Ports:
//   clk_in, rst_in          clock; asynchronous active-high reset
//   req_valid_in/ready_out  burst request handshake
//   req_addr_in             start address {bank, offset}
//   req_len_in              burst length minus one
//   en_b_out, we_b_out      SRAM port B enable / write enable (always 0)
//   addr_b_out, d_b_in      SRAM port B address / read data
//   dout_*                  output stream (valid, ready, data, last)
//   busy_out                high whenever not idle
//   stat_words_out          words delivered (only with SRAM_BURST_READER_STAT_EN)
//   stat_stall_out          cycles stalled by the sink (only with SRAM_BURST_READER_STAT_EN)
//
// Optional feature macro: SRAM_BURST_READER_STAT_EN

module sram_burst_reader #(
  parameter int DWIDTH     = 32,
  parameter int NRAMWIDHT  = 5,
  parameter int AWIDTH     = 13,
  parameter int LWIDTH     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        req_valid_in,
  output logic                        req_ready_out,
  input  logic [NRAMWIDHT+AWIDTH-1:0] req_addr_in,
  input  logic [LWIDTH-1:0]           req_len_in,
  output logic                        en_b_out,
  output logic                        we_b_out,
  output logic [NRAMWIDHT+AWIDTH-1:0] addr_b_out,
  input  logic [DWIDTH-1:0]           d_b_in,
  output logic                        dout_valid_out,
  input  logic                        dout_ready_in,
  output logic [DWIDTH-1:0]           dout_data_out,
  output logic                        dout_last_out,
`ifdef SRAM_BURST_READER_STAT_EN
  output logic [31:0]                 stat_words_out,
  output logic [31:0]                 stat_stall_out,
`endif
  output logic                        busy_out
);

  localparam int ADDR_W = NRAMWIDHT + AWIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = PTR_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NRAMWIDHT-1:0] bank_q;
  logic [AWIDTH-1:0]    offset_q;
  logic [LWIDTH-1:0]    remaining_q;
  logic [ADDR_W-1:0]    last_addr_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 issue;

  logic [DWIDTH:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     fifo_count_q;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [OCC_W-1:0]     occupancy;

  // Credit check counts the read already in flight, so its data always has
  // a slot when it lands one cycle later.
  assign occupancy  = OCC_W'(fifo_count_q) + OCC_W'(inflight_q);
  assign fifo_empty = (fifo_count_q == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        issue = (occupancy < OCC_W'(FIFO_DEPTH));
        if (issue && (remaining_q == '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_out = (state_q == ST_IDLE);
  assign busy_out      = (state_q != ST_IDLE);
  assign en_b_out      = issue;
  assign we_b_out      = 1'b0;
  // The address bus shows the live address only while a read is issued and
  // otherwise holds the most recently issued one.
  assign addr_b_out    = issue ? {bank_q, offset_q} : last_addr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_q          <= '0;
      offset_q        <= '0;
      remaining_q     <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if ((state_q == ST_IDLE) && req_valid_in) begin
        bank_q      <= req_addr_in[ADDR_W-1:AWIDTH];
        offset_q    <= req_addr_in[AWIDTH-1:0];
        remaining_q <= req_len_in;
      end else if (issue) begin
        // Offset wraps within the bank; the bank field is never touched.
        offset_q    <= offset_q + AWIDTH'(1);
        remaining_q <= remaining_q - LWIDTH'(1);
        last_addr_q <= {bank_q, offset_q};
      end
      if (issue) begin
        inflight_last_q <= (remaining_q == '0);
      end
    end
  end

  assign fifo_push = inflight_q;
  assign fifo_pop  = !fifo_empty && dout_ready_in;

  always_ff @(posedge clk_in) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= {inflight_last_q, d_b_in};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // Head is masked when empty so stale storage never reaches the outputs.
  assign dout_valid_out = !fifo_empty;
  assign dout_data_out  = fifo_empty ? '0 : fifo_mem[rd_ptr_q][DWIDTH-1:0];
  assign dout_last_out  = fifo_empty ? 1'b0 : fifo_mem[rd_ptr_q][DWIDTH];

`ifdef SRAM_BURST_READER_STAT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_words_out <= '0;
      stat_stall_out <= '0;
    end else begin
      if (dout_valid_out && dout_ready_in && (stat_words_out != '1)) begin
        stat_words_out <= stat_words_out + 32'd1;
      end
      if (dout_valid_out && !dout_ready_in && (stat_stall_out != '1)) begin
        stat_stall_out <= stat_stall_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb/tb_sram_burst_reader.sv - scoreboard bench for sram_burst_reader

module tb_sram_burst_reader;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int AT = 18;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [AT-1:0] req_addr_in = '0;
  logic [7:0]    req_len_in = '0;
  logic          en_b_out;
  logic          we_b_out;
  logic [AT-1:0] addr_b_out;
  logic [DW-1:0] d_b_in = '0;
  logic          dout_valid_out;
  logic          dout_ready_in = 1'b1;
  logic [DW-1:0] dout_data_out;
  logic          dout_last_out;
  logic          busy_out;
`ifdef SRAM_BURST_READER_STAT_EN
  logic [31:0]   stat_words_out;
  logic [31:0]   stat_stall_out;
`endif

  sram_burst_reader dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_addr_in   (req_addr_in),
    .req_len_in    (req_len_in),
    .en_b_out      (en_b_out),
    .we_b_out      (we_b_out),
    .addr_b_out    (addr_b_out),
    .d_b_in        (d_b_in),
    .dout_valid_out(dout_valid_out),
    .dout_ready_in (dout_ready_in),
    .dout_data_out (dout_data_out),
    .dout_last_out (dout_last_out),
`ifdef SRAM_BURST_READER_STAT_EN
    .stat_words_out(stat_words_out),
    .stat_stall_out(stat_stall_out),
`endif
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AT-1:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  int stalls = 0;
  int en_in_reset = 0;

  function automatic logic [DW-1:0] sram_word(input logic [AT-1:0] a);
    return 32'hC0DE_0000 ^ {14'h0, a};
  endfunction

  // SRAM port B model: registered read, data valid the cycle after enable.
  always @(posedge clk_in) begin
    if (en_b_out) d_b_in <= sram_word(addr_b_out);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard for every issued read and every delivered word.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (en_b_out) en_in_reset++;
    end else begin
      if (en_b_out) begin
        issued++;
        check("we_b", we_b_out, 0);
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("addr_b", addr_b_out, addr_q.pop_front());
      end
      if (dout_valid_out && dout_ready_in) begin
        word_t w;
        popped++;
        if (exp_q.size() == 0) check("unexpected_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          check("dout_data", dout_data_out, w.data);
          check("dout_last", dout_last_out, w.last);
        end
      end
      if (dout_valid_out && !dout_ready_in) stalls++;
    end
  end

  task automatic queue_burst(input logic [AT-1:0] a, input int len);
    logic [AW-1:0] off;
    logic [AT-1:0] ad;
    word_t w;
    for (int i = 0; i <= len; i++) begin
      off = a[AW-1:0] + AW'(i);
      ad  = {a[AT-1:AW], off};
      addr_q.push_back(ad);
      w.data = sram_word(ad);
      w.last = (i == len);
      exp_q.push_back(w);
    end
  endtask

  // Returns at handshake edge + 1.
  task automatic handshake(input logic [AT-1:0] a, input logic [7:0] l);
    @(posedge clk_in); #1;
    req_valid_in = 1'b1;
    req_addr_in  = a;
    req_len_in   = l;
    check("req_ready_before", req_ready_out, 1);
    @(posedge clk_in); #1;
    req_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (busy_out && n < 1000);
    check({"idle_", name}, busy_out, 0);
    check({"sb_empty_", name}, exp_q.size(), 0);
    check({"addrq_empty_", name}, addr_q.size(), 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_en_b"}, en_b_out, 0);
    check({name, "_we_b"}, we_b_out, 0);
    check({name, "_addr_b"}, addr_b_out, 0);
    check({name, "_dout_valid"}, dout_valid_out, 0);
    check({name, "_dout_data"}, dout_data_out, 0);
    check({name, "_dout_last"}, dout_last_out, 0);
    check({name, "_busy"}, busy_out, 0);
    check({name, "_req_ready"}, req_ready_out, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int i0, p0, s0, ok;
    logic [AT-1:0] wrap_tab [4];
    word_t w;
`ifdef SRAM_BURST_READER_STAT_EN
    logic [31:0] sw0, ss0;
`endif

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_values("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Single word, bank 3 offset 0x010.
    queue_burst(18'h06010, 0);
    i0 = issued;
    handshake(18'h06010, 8'd0);
    @(negedge clk_in);
    check("single_en_t1", en_b_out, 1);
    check("single_addr_t1", addr_b_out, 18'h06010);
    @(negedge clk_in);
    check("single_en_t2", en_b_out, 0);
    check("single_valid_t2", dout_valid_out, 0);
    @(negedge clk_in);
    check("single_valid_t3", dout_valid_out, 1);
    check("single_last_t3", dout_last_out, 1);
    wait_idle("single");
    check("single_issue_count", issued - i0, 1);
    check("single_req_ready", req_ready_out, 1);

    // Full-rate 16-word burst from address 0.
    queue_burst(18'h00000, 15);
    handshake(18'h00000, 8'd15);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (en_b_out) ok++;
    end
    check("full_rate_consecutive_en", ok, 16);
    @(negedge clk_in);
    check("full_rate_en_after", en_b_out, 0);
    wait_idle("full");

    // Offset wrap inside bank 2.
    wrap_tab[0] = 18'h05FFE;
    wrap_tab[1] = 18'h05FFF;
    wrap_tab[2] = 18'h04000;
    wrap_tab[3] = 18'h04001;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(wrap_tab[i]);
      w.data = sram_word(wrap_tab[i]);
      w.last = (i == 3);
      exp_q.push_back(w);
    end
    handshake(18'h05FFE, 8'd3);
    wait_idle("wrap");

    // Backpressure: sink stalls for 10 cycles mid-burst.
    i0 = issued;
    p0 = popped;
    s0 = stalls;
`ifdef SRAM_BURST_READER_STAT_EN
    sw0 = stat_words_out;
    ss0 = stat_stall_out;
`endif
    queue_burst(18'h00A20, 7);
    handshake(18'h00A20, 8'd7);
    repeat (4) @(posedge clk_in);
    #1 dout_ready_in = 1'b0;
    repeat (9) @(posedge clk_in);
    @(negedge clk_in);
    check("bp_en_stopped", en_b_out, 0);
    check("bp_outstanding", (issued - i0) - (popped - p0), 4);
    check("bp_popped_before_stall", popped - p0, 2);
    @(posedge clk_in); #1;
    dout_ready_in = 1'b1;
    wait_idle("bp");
    check("bp_words", popped - p0, 8);
    check("bp_issues", issued - i0, 8);
    check("bp_stalls", stalls - s0, 10);
`ifdef SRAM_BURST_READER_STAT_EN
    check("stat_words", stat_words_out - sw0, 8);
    check("stat_stall", stat_stall_out - ss0, 10);
`endif

    // Reset three cycles into a 21-word burst.
    queue_burst(18'h00100, 20);
    handshake(18'h00100, 8'd20);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1 check_reset_values("midreset");
    exp_q.delete();
    addr_q.delete();
    en_in_reset = 0;
    repeat (3) @(posedge clk_in);
    check("midreset_no_en", en_in_reset, 0);
    #1 rst_in = 1'b0;
`ifdef SRAM_BURST_READER_STAT_EN
    check("midreset_stat_words", stat_words_out, 0);
`endif
    p0 = popped;
    queue_burst(18'h00200, 1);
    handshake(18'h00200, 8'd1);
    wait_idle("after_reset");
    check("after_reset_words", popped - p0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-side burst controller that sits directly upstream of the banked dual-port SRAM array (`multi_sram`) and drives its port B. It accepts a burst request (start address plus length) and issues one SRAM read per cycle. It captures the 1-cycle-latency read data and delivers it as a valid/ready stream with a last-word marker. A credit-limited output FIFO absorbs downstream backpressure, so no read is ever issued without space for its data.

## Interface
- DWIDTH, 32, data word width; must equal the SRAM array's DWIDTH.
- NRAMWIDHT, 5, bank-select width; the upper address bits.
- AWIDTH, 13, in-bank offset width; the lower address bits.
- LWIDTH, 8, burst length field width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk_in  in  1  single clock for all logic and for the SRAM array.
- rst_in  in  1  reset, asynchronous, active-high.
- req_valid_in  in  1  burst request valid.
- req_ready_out  out  1  request accepted when high together with req_valid_in.
- req_addr_in  in  NRAMWIDHT+AWIDTH  start address as {bank, offset}.
- req_len_in  in  LWIDTH  burst length minus one; 0 means 1 word, max 2^LWIDTH words.
- en_b_out  out  1  to SRAM port B enable.
- we_b_out  out  1  to SRAM port B write enable; constant 0.
- addr_b_out  out  NRAMWIDHT+AWIDTH  to SRAM port B address.
- d_b_in  in  DWIDTH  from SRAM port B read data; valid the cycle after en_b_out.
- dout_valid_out  out  1  output word valid.
- dout_ready_in  in  1  sink ready.
- dout_data_out  out  DWIDTH  output word.
- dout_last_out  out  1  marks the final word of a burst.
- busy_out  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: req_ready_out=1. On a request handshake, latch the address and the remaining count, then go to READ.
  - READ: issue reads while allowed. After the issue with remaining=0, go to DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty, then go to IDLE.
- Issue rule: en_b_out=1 in READ only when fifo_count + inflight < FIFO_DEPTH.
  - inflight is a 1-bit register set on issue and cleared the following cycle.
- Address update: after each issue, the offset increments by 1 and wraps modulo 2^AWIDTH. The bank field never changes within a burst.
- Capture: in the cycle after an issue, push d_b_in into the FIFO together with a last tag. The tag is 1 iff that issue had remaining=0.
- Output:
  - The FIFO head drives dout_*.
  - Pop on dout_valid_out && dout_ready_in.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- Requests are not accepted during READ or DRAIN. A new burst's first word can never overtake a previous burst's last word.
- en_b_out is 0 and addr_b_out holds its last value whenever no read is issued.

## Timing
- Request handshake at edge T:
  - first en_b_out is high in cycle T+1;
  - first data is pushed at edge T+2;
  - dout_valid_out is high from cycle T+2 onward, after that edge.
- Throughput is 1 word/cycle when FIFO_DEPTH≥3 and dout_ready_in is held high.
- With FIFO_DEPTH=2 the issue rate is at most 1 per 2 cycles.
- Minimum burst occupancy is 1 (IDLE) + (len+1) issue cycles + 1 capture cycle + FIFO drain, before req_ready_out returns high.
- Reset values: en_b_out=0, we_b_out=0, addr_b_out=0, dout_valid_out=0, dout_data_out=0, dout_last_out=0, busy_out=0, req_ready_out=1 (IDLE).
- Reset mid-burst: the FSM returns to IDLE, the FIFO is emptied, inflight is cleared and in-progress data is discarded. No en_b_out is issued after reset asserts.

## Configuration
- SRAM_BURST_READER_STAT_EN defined:
  - adds stat_words_out (out, 32), counting words popped with dout_ready_in high;
  - adds stat_stall_out (out, 32), counting cycles with dout_valid_out && !dout_ready_in;
  - both counters saturate at 2^32-1 and reset to 0.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Single word: addr={bank 3, offset 0x010}, len=0, sink always ready.
  - Exactly one en_b_out, at T+1, with addr_b_out=0x6010.
  - One output word with dout_last_out=1.
  - req_ready_out back high at IDLE.
- Full-rate burst: addr=0x0000, len=15, FIFO_DEPTH=4, sink ready.
  - 16 consecutive en_b_out cycles.
  - Data equals SRAM contents 0..15 in order.
  - dout_last_out only on the 16th word.
- Offset wrap: offset 0x1FFE, bank 2, len=3.
  - addr_b_out sequence 0x5FFE, 0x5FFF, 0x4000, 0x4001; the bank stays 2.
- Backpressure: len=7, dout_ready_in low for 10 cycles mid-burst.
  - en_b_out stops once fifo_count+inflight=4.
  - No word is lost or duplicated; all 8 words arrive in order after ready returns.
- Reset mid-burst: assert rst_in 3 cycles into a len=20 burst.
  - All outputs reach their reset values immediately.
  - The next burst (len=1) returns exactly 2 correct words.
- With SRAM_BURST_READER_STAT_EN: run the backpressure case.
  - stat_words_out=8.
  - stat_stall_out equals the number of stalled valid cycles.
